// File: rtl/quad_steer_pkg.sv
// Shared definitions for the quadrature steering encoder.
// Holds the per-channel state encoding, the acceleration ceiling and the
// Gray-code successor functions for each steering direction.
// AB is packed as {A, B}; only one bit changes per step.
package quad_steer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN_R = 2'd1,
    RUN_L = 2'd2
  } steer_state_e;

  // Highest acceleration level (period = clkdiv >> level).
  localparam logic [1:0] MAX_LEVEL = 2'd2;

  // Right rotation: 00 -> 01 -> 11 -> 10 -> 00
  function automatic logic [1:0] gray_next_r(input logic [1:0] ab);
    case (ab)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  // Left rotation: 00 -> 10 -> 11 -> 01 -> 00
  function automatic logic [1:0] gray_next_l(input logic [1:0] ab);
    case (ab)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/quad_steer_chan.sv
// One steering channel: request decode, IDLE/RUN_R/RUN_L state machine,
// step-period prescaler, Gray phase register and optional hold-to-accelerate.
// Optional feature macro: QUAD_STEER_ACCEL_EN (period shrinks by halving after
// every ACCEL_STEPS consecutive same-direction steps, up to MAX_LEVEL).
// Ports:
//   CLK, reset    clock, asynchronous active-high reset
//   clkdiv        step period in CLK cycles, 0 = stalled
//   left, right   requests, active high (both or neither = idle)
//   steer         registered quadrature phase {A, B}
//   step          one-cycle pulse coinciding with a new phase
//   dir           direction of the last step, 1 = right
module quad_steer_chan
  import quad_steer_pkg::*;
#(
  parameter int DIV_W       = 16,
  parameter int ACCEL_STEPS = 8
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic [DIV_W-1:0] clkdiv,
  input  logic             left,
  input  logic             right,
  output logic [1:0]       steer,
  output logic             step,
  output logic             dir
);

  if (ACCEL_STEPS < 1) begin : g_bad_accel
    $error("ACCEL_STEPS must be at least 1");
  end

  steer_state_e     state_p0, state_nxt;
  logic [DIV_W-1:0] pres_p0;
  logic [DIV_W-1:0] period;
  logic [1:0]       phase_p0;
  logic             step_p0;
  logic             dir_p0;
  logic             req_r, req_l;
  logic             run_hold;
  logic             fire;

  assign req_r = right & ~left;
  assign req_l = left & ~right;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) state_p0 <= IDLE;
    else       state_p0 <= state_nxt;
  end

  // The request alone selects the state, so IDLE->RUN, RUN->IDLE and a
  // direct reversal all fall out of the same decode.
  always_comb begin
    state_nxt = IDLE;
    if (req_r)      state_nxt = RUN_R;
    else if (req_l) state_nxt = RUN_L;
  end

  // Counting happens only while staying in the same run; any transition
  // (including reversal) restarts the prescaler from zero.
  assign run_hold = (state_p0 != IDLE) && (state_nxt == state_p0);
  assign fire     = run_hold && (period != '0) && (pres_p0 == period - 1'b1);

`ifdef QUAD_STEER_ACCEL_EN
  localparam int TALLY_W = $clog2(ACCEL_STEPS + 1);

  logic [1:0]         level_p0;
  logic [TALLY_W-1:0] tally_p0;
  logic [DIV_W-1:0]   shifted;

  assign shifted = clkdiv >> level_p0;
  // A small nonzero clkdiv must not shift down to a stall.
  assign period  = ((clkdiv != '0) && (shifted == '0)) ? DIV_W'(1) : shifted;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      level_p0 <= 2'd0;
      tally_p0 <= '0;
    end else if (!run_hold) begin
      level_p0 <= 2'd0;
      tally_p0 <= '0;
    end else if (fire) begin
      if (tally_p0 == TALLY_W'(ACCEL_STEPS - 1)) begin
        tally_p0 <= '0;
        if (level_p0 < MAX_LEVEL) level_p0 <= level_p0 + 2'd1;
      end else begin
        tally_p0 <= tally_p0 + 1'b1;
      end
    end
  end
`else
  assign period = clkdiv;
`endif

  // ---- stage p0: prescaler, phase and strobe registers ----
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      pres_p0  <= '0;
      phase_p0 <= 2'b00;
      step_p0  <= 1'b0;
      dir_p0   <= 1'b0;
    end else begin
      step_p0 <= fire;
      if (!run_hold || fire || (period == '0)) pres_p0 <= '0;
      else                                     pres_p0 <= pres_p0 + 1'b1;
      if (fire) begin
        phase_p0 <= (state_p0 == RUN_R) ? gray_next_r(phase_p0) : gray_next_l(phase_p0);
        dir_p0   <= (state_p0 == RUN_R);
      end
    end
  end

  assign steer = phase_p0;
  assign step  = step_p0;
  assign dir   = dir_p0;

endmodule

// File: rtl/quad_steer_multi.sv
// Multi-channel joystick-to-quadrature steering encoder. Each channel turns
// its left/right request into a 2-bit Gray stream at a shared step period.
// Optional feature macro: QUAD_STEER_ACCEL_EN (hold-to-accelerate ramp).
// Ports:
//   CLK, reset    clock, asynchronous active-high reset
//   clkdiv        step period in CLK cycles, shared, 0 = stalled
//   left, right   per-channel requests, active high
//   steer         channel i: steer[2i+1] = A, steer[2i] = B
//   step          per-channel one-cycle step pulse
//   dir           per-channel last step direction, 1 = right
module quad_steer_multi
  import quad_steer_pkg::*;
#(
  parameter int CHANNELS    = 2,
  parameter int DIV_W       = 16,
  parameter int ACCEL_STEPS = 8
) (
  input  logic                  CLK,
  input  logic                  reset,
  input  logic [DIV_W-1:0]      clkdiv,
  input  logic [CHANNELS-1:0]   left,
  input  logic [CHANNELS-1:0]   right,
  output logic [2*CHANNELS-1:0] steer,
  output logic [CHANNELS-1:0]   step,
  output logic [CHANNELS-1:0]   dir
);

  if ((CHANNELS < 1) || (CHANNELS > 4)) begin : g_bad_channels
    $error("CHANNELS must be in 1..4");
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    quad_steer_chan #(
      .DIV_W      (DIV_W),
      .ACCEL_STEPS(ACCEL_STEPS)
    ) u_chan (
      .CLK   (CLK),
      .reset (reset),
      .clkdiv(clkdiv),
      .left  (left[i]),
      .right (right[i]),
      .steer (steer[2*i +: 2]),
      .step  (step[i]),
      .dir   (dir[i])
    );
  end

endmodule

// File: tb/tb_quad_steer_multi.sv
// Self-checking bench for quad_steer_multi: table of from-reset vectors with
// hand-derived final results, a cycle scoreboard fed by a reference model,
// and hand-written sequences for reversal, stall, async reset and accel.
module tb_quad_steer_multi;

  localparam int CH = 2;
  localparam int DW = 16;
  localparam int AS = 8;

  logic            CLK = 1'b0;
  logic            reset;
  logic [DW-1:0]   clkdiv;
  logic [CH-1:0]   left, right;
  logic [2*CH-1:0] steer;
  logic [CH-1:0]   step, dir;

  int checks   = 0;
  int failures = 0;

  quad_steer_multi #(.CHANNELS(CH), .DIV_W(DW), .ACCEL_STEPS(AS)) dut (
    .CLK(CLK), .reset(reset), .clkdiv(clkdiv), .left(left), .right(right),
    .steer(steer), .step(step), .dir(dir)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [3:0] steer;
    logic [1:0] step;
    logic [1:0] dir;
  } outs_t;

  typedef struct {
    logic [1:0]  l, r;
    logic [15:0] div;
    int          cyc;
    logic [3:0]  e_steer;
    int          e_s0, e_s1;
    logic [1:0]  e_dir;
  } vec_t;

  outs_t      exp_q[$];
  vec_t       vec[6];
  logic [1:0] gray_tab[4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  // reference model state (run: 0 idle, 1 right, 2 left)
  int   m_run[CH], m_el[CH], m_pos[CH], m_lvl[CH], m_tal[CH];
  logic m_dir[CH];
  int   cnt[CH];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, want, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_run[c] = 0; m_el[c] = 0; m_pos[c] = 0; m_lvl[c] = 0; m_tal[c] = 0;
      m_dir[c] = 1'b0; cnt[c] = 0;
    end
    exp_q.delete();
  endtask

  task automatic model_edge(output outs_t e);
    int req, per;
    e = '0;
    for (int c = 0; c < CH; c++) begin
      req = (right[c] && !left[c]) ? 1 : (left[c] && !right[c]) ? 2 : 0;
      if (req == 0 || req != m_run[c]) begin
        m_el[c] = 0; m_lvl[c] = 0; m_tal[c] = 0;
      end else begin
        per = int'(clkdiv) >> m_lvl[c];
        if (clkdiv != 0 && per == 0) per = 1;
        if (per == 0) m_el[c] = 0;
        else begin
          m_el[c]++;
          if (m_el[c] == per) begin
            m_el[c]   = 0;
            e.step[c] = 1'b1;
            m_dir[c]  = (req == 1);
            m_pos[c]  = (req == 1) ? (m_pos[c] + 1) % 4 : (m_pos[c] + 3) % 4;
`ifdef QUAD_STEER_ACCEL_EN
            m_tal[c]++;
            if (m_tal[c] == AS) begin
              m_tal[c] = 0;
              if (m_lvl[c] < 2) m_lvl[c]++;
            end
`endif
          end
        end
      end
      m_run[c] = req;
      e.steer[2*c +: 2] = gray_tab[m_pos[c]];
      e.dir[c] = m_dir[c];
    end
  endtask

  // One clock: model predicts, scoreboard queues, DUT sampled 1 ns after edge.
  task automatic tick();
    outs_t e, g;
    model_edge(e);
    exp_q.push_back(e);
    @(posedge CLK); #1;
    g.steer = steer; g.step = step; g.dir = dir;
    e = exp_q.pop_front();
    chk("sb_steer", g.steer, e.steer);
    chk("sb_step",  g.step,  e.step);
    chk("sb_dir",   g.dir,   e.dir);
    for (int c = 0; c < CH; c++) if (step[c]) cnt[c]++;
  endtask

  task automatic do_reset();
    left = '0; right = '0;
    #2 reset = 1'b1;
    #1;
    chk("rst_steer", steer, 0);
    chk("rst_step",  step,  0);
    chk("rst_dir",   dir,   0);
    model_reset();
    @(posedge CLK); #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, prev, nst;
    bit done;
    reset = 1'b1; clkdiv = '0; left = '0; right = '0;
    model_reset();

    //             l      r      div cyc steer    s0 s1 dir
    vec[0] = '{2'b00, 2'b01, 16'd4, 14, 4'b0010, 3, 0, 2'b01};
    vec[1] = '{2'b01, 2'b01, 16'd4, 40, 4'b0000, 0, 0, 2'b00};
    vec[2] = '{2'b10, 2'b01, 16'd3,  9, 4'b0110, 3, 3, 2'b01};
    vec[3] = '{2'b00, 2'b11, 16'd0, 20, 4'b0000, 0, 0, 2'b00};
    vec[4] = '{2'b11, 2'b00, 16'd1,  5, 4'b1010, 5, 5, 2'b00};
    vec[5] = '{2'b00, 2'b10, 16'd2,  7, 4'b1000, 0, 3, 2'b10};

    for (int i = 0; i < 6; i++) begin
      do_reset();
      clkdiv = vec[i].div; left = vec[i].l; right = vec[i].r;
      for (int k = 0; k <= vec[i].cyc; k++) tick();
      chk("vec_steer",  steer,  vec[i].e_steer);
      chk("vec_steps0", cnt[0], vec[i].e_s0);
      chk("vec_steps1", cnt[1], vec[i].e_s1);
      chk("vec_dir",    dir,    vec[i].e_dir);
    end

    // reversal: right for 6 cycles then left
    do_reset();
    clkdiv = 16'd4; right = 2'b01;
    for (int k = 0; k <= 5; k++) begin
      tick();
      if (k == 4) begin
        chk("rev_first_ab",  steer[1:0], 2'b01);
        chk("rev_first_dir", dir[0],     1'b1);
      end
    end
    right = 2'b00; left = 2'b01;
    for (int k = 6; k <= 10; k++) begin
      tick();
      if (k == 9) chk("rev_no_early_step", step[0], 1'b0);
      if (k == 10) begin
        chk("rev_back_ab",  steer[1:0], 2'b00);
        chk("rev_step",     step[0],    1'b1);
        chk("rev_dir_left", dir[0],     1'b0);
      end
    end

    // stalled then period 2
    do_reset();
    clkdiv = 16'd0; right = 2'b01;
    for (int k = 0; k < 10; k++) tick();
    chk("stall_steps", cnt[0], 0);
    clkdiv = 16'd2;
    for (int k = 0; k < 6; k++) tick();
    chk("div2_steps", cnt[0], 3);
    chk("div2_ab",    steer[1:0], 2'b10);

    // async reset mid-run at AB=11
    do_reset();
    clkdiv = 16'd4; right = 2'b01;
    for (int k = 0; k <= 8; k++) tick();
    chk("mid_ab",   steer[1:0], 2'b11);
    chk("mid_step", step[0],    1'b1);
    #2 reset = 1'b1;
    #1;
    chk("async_steer", steer, 0);
    chk("async_step",  step,  0);
    chk("async_dir",   dir,   0);
    model_reset();
    @(posedge CLK); #1;
    reset = 1'b0;

`ifdef QUAD_STEER_ACCEL_EN
    do_reset();
    clkdiv = 16'd8; right = 2'b01;
    n = 0; prev = 0; nst = 0;
    while (nst < 24 && n < 300) begin
      tick();
      if (step[0]) begin
        chk("accel_gap", n - prev, (nst < 8) ? 8 : (nst < 16) ? 4 : 2);
        prev = n;
        nst++;
      end
      n++;
    end
    if (nst < 24) chk("accel_timeout", nst, 24);
    right = 2'b00; tick();
    right = 2'b01;
    n = 0; done = 1'b0;
    while (!done && n < 50) begin
      tick();
      if (step[0]) begin
        chk("accel_restart_gap", n, 8);
        done = 1'b1;
      end
      n++;
    end
    if (!done) chk("accel_restart_timeout", 0, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
